// File: rtl/alu_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl_if
// Bus bundle between the ALU sequencer and its environment.
//   Request port  : req_valid/req_ready handshake with req_op, req_a, req_b, req_wb
//   Datapath port : op_a, op_b, sel (one-hot result select), acc (REG source),
//                   alu_res (combined result returned by the datapath)
//   Response port : rsp_valid/rsp_ready handshake with rsp_data, rsp_err
// Modports:
//   slave  - the sequencer itself
//   master - the requester / datapath / response consumer side
// -----------------------------------------------------------------------------
interface alu_seq_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             req_wb;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [5:0]       sel;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] alu_res;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err;

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_wb, alu_res, rsp_ready,
      output req_ready, op_a, op_b, sel, acc, rsp_valid, rsp_data, rsp_err
   );

   modport master (
      output req_valid, req_op, req_a, req_b, req_wb, alu_res, rsp_ready,
      input  req_ready, op_a, op_b, sel, acc, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Sequencer for the 6-way ALU result select stage (AND, OR, NOT, XOR, SUM, REG).
// Takes one operation at a time, drives the latched operands and a one-hot
// result select into the datapath, waits the settle latency, captures the
// combined result and returns it over a valid/ready response port. It also
// owns the accumulator that feeds the datapath REG source.
// Ports:
//   clk  - single clock, all state on the rising edge
//   rst  - synchronous, active-high reset (discards any in-flight op)
//   bus  - alu_seq_ctrl_if.slave: request, datapath and response signals
// Opcodes: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 SUM, 5 REG, 6 LOAD, 7 illegal.
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
   parameter int WIDTH     = 8,
   parameter int LOGIC_LAT = 1,   // select hold cycles for ops 0-3 and 5, min 1
   parameter int SUM_LAT   = 3    // select hold cycles for op 4, min 1
) (
   input  logic          clk,
   input  logic          rst,
   alu_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter only ever holds LAT-1, so size it for the larger latency minus one.
   localparam int MAX_LAT = (SUM_LAT > LOGIC_LAT) ? SUM_LAT : LOGIC_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [2:0] OP_SUM  = 3'd4;
   localparam logic [2:0] OP_LOAD = 3'd6;
   localparam logic [2:0] OP_ILL  = 3'd7;

   localparam logic [CNT_W-1:0] CNT_SUM   = CNT_W'(SUM_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_LOGIC = CNT_W'(LOGIC_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [5:0]       sel_q,   sel_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic             wb_q,    wb_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] acc_q,   acc_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic             err_q,   err_d;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         wb_q    <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         a_q     <= a_d;
         b_q     <= b_d;
         wb_q    <= wb_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      a_d     = a_q;
      b_d     = b_q;
      wb_d    = wb_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      data_d  = data_q;
      err_d   = err_q;

      unique case (state_q)
         IDLE: begin
            // req_ready is 1 throughout IDLE, so req_valid alone is the handshake.
            if (bus.req_valid) begin
               a_d  = bus.req_a;
               b_d  = bus.req_b;
               wb_d = bus.req_wb;
               if (bus.req_op == OP_LOAD) begin
                  // LOAD bypasses the datapath and always writes the accumulator.
                  data_d  = bus.req_a;
                  err_d   = 1'b0;
                  acc_d   = bus.req_a;
                  state_d = DONE;
               end else if (bus.req_op == OP_ILL) begin
                  data_d  = '0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  // Registered select keeps sel glitch-free towards the datapath.
                  sel_d   = 6'b000001 << bus.req_op;
                  cnt_d   = (bus.req_op == OP_SUM) ? CNT_SUM : CNT_LOGIC;
                  state_d = EXEC;
               end
            end
         end

         EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               // REG reads acc_q, which has not moved during EXEC, so a REG
               // with wb rewrites the pre-op value.
               data_d  = bus.alu_res;
               err_d   = 1'b0;
               if (wb_q) begin
                  acc_d = bus.alu_res;
               end
               sel_d   = '0;
               state_d = DONE;
            end
         end

         DONE: begin
            // Returning to IDLE forces one idle cycle before the next accept.
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            sel_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == DONE);
   assign bus.op_a      = a_q;
   assign bus.op_b      = b_q;
   assign bus.sel       = sel_q;
   assign bus.acc       = acc_q;
   assign bus.rsp_data  = data_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Self-checking bench for alu_seq_ctrl. Contains a datapath model that returns
// corrupted data until the select has settled for the required latency, and a
// reference model (accumulator + per-opcode arithmetic) for expected results.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;
   localparam int WIDTH     = 8;
   localparam int LOGIC_LAT = 1;
   localparam int SUM_LAT   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_seq_ctrl_if #(.WIDTH(WIDTH)) bif ();

   alu_seq_ctrl #(
      .WIDTH    (WIDTH),
      .LOGIC_LAT(LOGIC_LAT),
      .SUM_LAT  (SUM_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif)
   );

   int n_chk  = 0;
   int n_fail = 0;
   logic [7:0] acc_m = 8'h00;   // reference accumulator

   // ---------------- datapath model ----------------
   int         held = 0;        // cycles sel has been visible, minus one
   logic [5:0] sel_prev = 6'd0;
   logic [7:0] dp_r;
   int         dp_need;

   always @(posedge clk) begin
      if (bif.sel == 6'd0)          held <= 0;
      else if (bif.sel == sel_prev) held <= held + 1;
      else                          held <= 1;
      sel_prev <= bif.sel;
   end

   always_comb begin
      dp_r    = 8'h00;
      dp_need = (bif.sel[4]) ? SUM_LAT : LOGIC_LAT;
      case (bif.sel)
         6'b000001: dp_r = bif.op_a & bif.op_b;
         6'b000010: dp_r = bif.op_a | bif.op_b;
         6'b000100: dp_r = ~bif.op_a;
         6'b001000: dp_r = bif.op_a ^ bif.op_b;
         6'b010000: dp_r = bif.op_a + bif.op_b;
         6'b100000: dp_r = bif.acc;
         6'b000000: dp_r = 8'h00;
         default:   dp_r = 8'hDE;
      endcase
      bif.alu_res = (held + 1 >= dp_need) ? dp_r : ~dp_r;
   end

   // sel must be zero or one-hot, and zero whenever idle or responding.
   int sel_bad = 0;
   always @(negedge clk) begin
      if (((bif.sel & (bif.sel - 6'd1)) != 6'd0) ||
          ((bif.sel != 6'd0) && (bif.rsp_valid || bif.req_ready)))
         sel_bad <= sel_bad + 1;
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] ref_res(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] acc);
      case (op)
         3'd0: ref_res = a & b;
         3'd1: ref_res = a | b;
         3'd2: ref_res = ~a;
         3'd3: ref_res = a ^ b;
         3'd4: ref_res = 8'((9'(a) + 9'(b)) % 256);
         3'd5: ref_res = acc;
         3'd6: ref_res = a;
         default: ref_res = 8'h00;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op);
      if (op == 3'd4)      ref_lat = 1 + SUM_LAT;
      else if (op <= 3'd5) ref_lat = 1 + LOGIC_LAT;
      else                 ref_lat = 1;
   endfunction

   // ---------------- driver (no checking) ----------------
   // Must be entered at a negedge; returns at a negedge.
   task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic wb, input bit rdy_early, input bit release_rsp,
                         output int lat, output logic [7:0] data, output logic err,
                         output logic [7:0] acc_o, output logic [5:0] sel_or,
                         output int sel_cyc, output bit tmo,
                         output logic post_valid, output logic post_ready);
      int n;
      tmo = 0; lat = 0; data = 8'h00; err = 1'b0; acc_o = 8'h00;
      sel_or = 6'd0; sel_cyc = 0; post_valid = 1'b0; post_ready = 1'b0;
      n = 0;
      while (!bif.req_ready && n < 50) begin @(negedge clk); n++; end
      if (!bif.req_ready) begin tmo = 1; return; end
      bif.req_valid = 1'b1; bif.req_op = op; bif.req_a = a; bif.req_b = b; bif.req_wb = wb;
      bif.rsp_ready = rdy_early;
      @(negedge clk);
      bif.req_valid = 1'b0;
      lat = 1;
      while (!bif.rsp_valid && lat < 50) begin
         if (bif.sel != 6'd0) begin sel_or = sel_or | bif.sel; sel_cyc++; end
         @(negedge clk);
         lat++;
      end
      if (bif.sel != 6'd0) begin sel_or = sel_or | bif.sel; sel_cyc++; end
      if (!bif.rsp_valid) begin tmo = 1; bif.rsp_ready = 1'b0; return; end
      data = bif.rsp_data; err = bif.rsp_err; acc_o = bif.acc;
      if (release_rsp) begin
         bif.rsp_ready = 1'b1;
         @(negedge clk);
         bif.rsp_ready = 1'b0;
         post_valid = bif.rsp_valid;
         post_ready = bif.req_ready;
      end
   endtask

   int lat, sc; logic [7:0] d, ac; logic e, pv, pr; logic [5:0] so; bit to;

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      acc_m = 8'h00;
      n_chk++; if (bif.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bif.req_ready); end
      n_chk++; if (bif.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bif.rsp_valid); end
      n_chk++; if (bif.sel !== 6'd0)       begin n_fail++; $display("FAIL reset_sel: got %b want 000000", bif.sel); end
      n_chk++; if (bif.op_a !== 8'h00)     begin n_fail++; $display("FAIL reset_op_a: got %h want 00", bif.op_a); end
      n_chk++; if (bif.op_b !== 8'h00)     begin n_fail++; $display("FAIL reset_op_b: got %h want 00", bif.op_b); end
      n_chk++; if (bif.acc !== 8'h00)      begin n_fail++; $display("FAIL reset_acc: got %h want 00", bif.acc); end
      n_chk++; if (bif.rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 00", bif.rsp_data); end
      n_chk++; if (bif.rsp_err !== 1'b0)   begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", bif.rsp_err); end
   endtask

   task automatic test_load();
      run_op(3'd6, 8'h5A, 8'h11, 1'b0, 1'b0, 1'b1, lat, d, e, ac, so, sc, to, pv, pr);
      acc_m = 8'h5A;
      n_chk++; if (to !== 1'b0)   begin n_fail++; $display("FAIL load_timeout: got %b want 0", to); end
      n_chk++; if (lat !== 1)     begin n_fail++; $display("FAIL load_lat: got %0d want 1", lat); end
      n_chk++; if (d !== 8'h5A)   begin n_fail++; $display("FAIL load_data: got %h want 5a", d); end
      n_chk++; if (e !== 1'b0)    begin n_fail++; $display("FAIL load_err: got %b want 0", e); end
      n_chk++; if (ac !== 8'h5A)  begin n_fail++; $display("FAIL load_acc: got %h want 5a", ac); end
      n_chk++; if (so !== 6'd0)   begin n_fail++; $display("FAIL load_sel: got %b want 000000", so); end
      n_chk++; if (pv !== 1'b0 || pr !== 1'b1) begin n_fail++; $display("FAIL load_release: got valid=%b ready=%b want 0/1", pv, pr); end
   endtask

   task automatic test_and();
      run_op(3'd0, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1, lat, d, e, ac, so, sc, to, pv, pr);
      n_chk++; if (lat !== 2)         begin n_fail++; $display("FAIL and_lat: got %0d want 2", lat); end
      n_chk++; if (d !== 8'h30)       begin n_fail++; $display("FAIL and_data: got %h want 30", d); end
      n_chk++; if (so !== 6'b000001)  begin n_fail++; $display("FAIL and_sel: got %b want 000001", so); end
      n_chk++; if (sc !== 1)          begin n_fail++; $display("FAIL and_sel_cycles: got %0d want 1", sc); end
      n_chk++; if (ac !== acc_m)      begin n_fail++; $display("FAIL and_acc: got %h want %h", ac, acc_m); end
   endtask

   task automatic test_sum_wrap();
      run_op(3'd4, 8'hFF, 8'h02, 1'b1, 1'b0, 1'b1, lat, d, e, ac, so, sc, to, pv, pr);
      acc_m = 8'h01;
      n_chk++; if (lat !== 4)         begin n_fail++; $display("FAIL sum_lat: got %0d want 4", lat); end
      n_chk++; if (d !== 8'h01)       begin n_fail++; $display("FAIL sum_data: got %h want 01", d); end
      n_chk++; if (so !== 6'b010000)  begin n_fail++; $display("FAIL sum_sel: got %b want 010000", so); end
      n_chk++; if (sc !== 3)          begin n_fail++; $display("FAIL sum_sel_cycles: got %0d want 3", sc); end
      n_chk++; if (ac !== 8'h01)      begin n_fail++; $display("FAIL sum_acc: got %h want 01", ac); end
   endtask

   task automatic test_illegal_then_reg();
      run_op(3'd7, 8'hC3, 8'h77, 1'b1, 1'b0, 1'b1, lat, d, e, ac, so, sc, to, pv, pr);
      n_chk++; if (e !== 1'b1)   begin n_fail++; $display("FAIL ill_err: got %b want 1", e); end
      n_chk++; if (d !== 8'h00)  begin n_fail++; $display("FAIL ill_data: got %h want 00", d); end
      n_chk++; if (ac !== acc_m) begin n_fail++; $display("FAIL ill_acc: got %h want %h", ac, acc_m); end
      n_chk++; if (so !== 6'd0)  begin n_fail++; $display("FAIL ill_sel: got %b want 000000", so); end
      n_chk++; if (lat !== 1)    begin n_fail++; $display("FAIL ill_lat: got %0d want 1", lat); end
      run_op(3'd5, 8'h9E, 8'h4B, 1'b1, 1'b0, 1'b1, lat, d, e, ac, so, sc, to, pv, pr);
      n_chk++; if (d !== acc_m)       begin n_fail++; $display("FAIL reg_data: got %h want %h", d, acc_m); end
      n_chk++; if (e !== 1'b0)        begin n_fail++; $display("FAIL reg_err: got %b want 0", e); end
      n_chk++; if (so !== 6'b100000)  begin n_fail++; $display("FAIL reg_sel: got %b want 100000", so); end
      n_chk++; if (ac !== acc_m)      begin n_fail++; $display("FAIL reg_acc: got %h want %h", ac, acc_m); end
   endtask

   task automatic test_backpressure();
      logic [7:0] a, b, exp;
      a = 8'($urandom); b = 8'($urandom); exp = a ^ b;
      run_op(3'd3, a, b, 1'b0, 1'b0, 1'b0, lat, d, e, ac, so, sc, to, pv, pr);
      n_chk++; if (d !== exp) begin n_fail++; $display("FAIL bp_data: got %h want %h", d, exp); end
      bif.req_valid = 1'b1; bif.req_op = 3'd6; bif.req_a = 8'hAA; bif.req_wb = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_chk++; if (bif.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bif.rsp_valid); end
         n_chk++; if (bif.rsp_data !== exp)   begin n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", i, bif.rsp_data, exp); end
         n_chk++; if (bif.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bif.req_ready); end
      end
      bif.req_valid = 1'b0;
      bif.rsp_ready = 1'b1;
      @(negedge clk);
      bif.rsp_ready = 1'b0;
      n_chk++; if (bif.rsp_valid !== 1'b0 || bif.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", bif.rsp_valid, bif.req_ready); end
      n_chk++; if (bif.acc !== acc_m) begin n_fail++; $display("FAIL bp_acc: got %h want %h", bif.acc, acc_m); end
      run_op(3'd6, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1, lat, d, e, ac, so, sc, to, pv, pr);
      acc_m = 8'h3C;
      n_chk++; if (to !== 1'b0 || d !== 8'h3C) begin n_fail++; $display("FAIL bp_next: got tmo=%b data=%h want 0/3c", to, d); end
   endtask

   task automatic test_reset_mid_exec();
      bit saw_valid;
      bif.req_valid = 1'b1; bif.req_op = 3'd4; bif.req_a = 8'h80; bif.req_b = 8'h81; bif.req_wb = 1'b1;
      @(negedge clk);
      bif.req_valid = 1'b0;
      n_chk++; if (bif.sel !== 6'b010000) begin n_fail++; $display("FAIL rst_exec_sel: got %b want 010000", bif.sel); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      acc_m = 8'h00;
      n_chk++; if (bif.sel !== 6'd0)       begin n_fail++; $display("FAIL rst_mid_sel: got %b want 000000", bif.sel); end
      n_chk++; if (bif.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", bif.req_ready); end
      n_chk++; if (bif.acc !== 8'h00)      begin n_fail++; $display("FAIL rst_mid_acc: got %h want 00", bif.acc); end
      saw_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bif.rsp_valid) saw_valid = 1'b1;
         @(negedge clk);
      end
      n_chk++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rsp: got rsp_valid=%b want 0", saw_valid); end
   endtask

   task automatic test_random_back_to_back();
      logic [2:0] op; logic [7:0] a, b, exp; logic wb; bit early;
      int exp_sc; logic [5:0] exp_so;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
         wb = 1'($urandom); early = 1'($urandom);
         exp    = ref_res(op, a, b, acc_m);
         exp_so = (op <= 3'd5) ? (6'b000001 << op) : 6'd0;
         exp_sc = (op == 3'd4) ? SUM_LAT : ((op <= 3'd5) ? LOGIC_LAT : 0);
         if (op == 3'd6 || (op <= 3'd5 && wb)) acc_m = exp;
         run_op(op, a, b, wb, early, 1'b1, lat, d, e, ac, so, sc, to, pv, pr);
         n_chk++; if (to !== 1'b0)          begin n_fail++; $display("FAIL rnd%0d_timeout op=%0d: got 1 want 0", i, op); end
         n_chk++; if (lat !== ref_lat(op))  begin n_fail++; $display("FAIL rnd%0d_lat op=%0d: got %0d want %0d", i, op, lat, ref_lat(op)); end
         n_chk++; if (d !== exp)            begin n_fail++; $display("FAIL rnd%0d_data op=%0d: got %h want %h", i, op, d, exp); end
         n_chk++; if (e !== (op == 3'd7))   begin n_fail++; $display("FAIL rnd%0d_err op=%0d: got %b want %b", i, op, e, (op == 3'd7)); end
         n_chk++; if (ac !== acc_m)         begin n_fail++; $display("FAIL rnd%0d_acc op=%0d: got %h want %h", i, op, ac, acc_m); end
         n_chk++; if (so !== exp_so)        begin n_fail++; $display("FAIL rnd%0d_sel op=%0d: got %b want %b", i, op, so, exp_so); end
         n_chk++; if (sc !== exp_sc)        begin n_fail++; $display("FAIL rnd%0d_sel_cycles op=%0d: got %0d want %0d", i, op, sc, exp_sc); end
         n_chk++; if (pv !== 1'b0 || pr !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_release: got valid=%b ready=%b want 0/1", i, pv, pr); end
      end
   endtask

   task automatic test_sel_invariant();
      n_chk++; if (sel_bad !== 0) begin n_fail++; $display("FAIL sel_onehot: got %0d bad cycles want 0", sel_bad); end
   endtask

   initial begin
      bif.req_valid = 1'b0; bif.req_op = 3'd0; bif.req_a = 8'h00; bif.req_b = 8'h00;
      bif.req_wb = 1'b0; bif.rsp_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_load();
      test_and();
      test_sum_wrap();
      test_illegal_then_reg();
      test_backpressure();
      test_reset_mid_exec();
      test_random_back_to_back();
      test_sel_invariant();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete within the time limit");
      $fatal(1, "bench time limit reached");
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencer for the 6-way ALU result select stage (AND, OR, NOT, XOR, SUM, REG sources).
- Accepts one operation at a time over a valid/ready request port and latches the operands.
- Drives the datapath operands and a one-hot result select, waits the configured settle latency, then captures the combined result.
- Returns the result over a valid/ready response port and owns the accumulator register that feeds the REG source.

Parameters:
- WIDTH, 8, datapath width in bits.
- LOGIC_LAT, 1, cycles the select is held for ops 0-3 and 5 (min 1).
- SUM_LAT, 3, cycles the select is held for op 4 (min 1).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  3  opcode: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 SUM, 5 REG, 6 LOAD, 7 illegal.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_wb  in  1  write the result to the accumulator.
- op_a  out  WIDTH  latched A to the datapath.
- op_b  out  WIDTH  latched B to the datapath.
- sel  out  6  one-hot result select; bit i = opcode i (bit0 AND ... bit5 REG).
- acc  out  WIDTH  accumulator value, drives the datapath REG source.
- alu_res  in  WIDTH  combined datapath result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  result.
- rsp_err  out  1  illegal opcode flag, qualified by rsp_valid.

Behaviour:
- Reset values: state IDLE, req_ready=1, sel=0, op_a=op_b=0, acc=0, rsp_valid=0, rsp_data=0, rsp_err=0, counter=0.
- Reset applies from any state. An in-flight op is discarded with no response and no accumulator write.

States: IDLE, EXEC, DONE.

IDLE:
- req_ready=1 and sel=0.
- A request is accepted on req_valid && req_ready. The block latches op, a, b and wb.
- Ops 0-5: go to EXEC. sel=onehot(op) from the next cycle. counter=(op==4 ? SUM_LAT : LOGIC_LAT)-1.
- Op 6 (LOAD): no datapath use, sel stays 0. Set rsp_data=a and rsp_err=0. acc<=a regardless of wb. Go to DONE.
- Op 7: set rsp_err=1 and rsp_data=0. acc is unchanged. Go to DONE.

EXEC:
- req_ready=0. sel, op_a and op_b are held stable.
- If counter != 0: decrement.
- If counter == 0: rsp_data<=alu_res, rsp_err<=0, and acc<=alu_res if wb. Go to DONE. sel drops to 0 in that cycle's next state.

DONE:
- rsp_valid=1 and req_ready=0.
- rsp_data and rsp_err are held until rsp_ready.
- On rsp_ready: go to IDLE. rsp_valid deasserts the next cycle.
- No new request is accepted in the same cycle as response handshake; there is one IDLE cycle minimum between ops.

Sel invariant: sel is one-hot in EXEC and all-zero in every other state. It is never multi-hot.

Latency: from the accept edge, rsp_valid rises after 1+LAT cycles for ops 0-5 and after 1 cycle for ops 6 and 7.

Accumulator:
- Op 5 (REG) reads the acc value as it was before the op.
- REG with wb rewrites the same value.
- acc changes only at the EXEC capture edge or the LOAD accept edge.

Width rules:
- All data is WIDTH bits. The SUM carry-out is not visible to this block; wrap-around is the datapath's behaviour and is passed through unchanged.

Backpressure:
- rsp_ready may be held low indefinitely. The response stays stable and req_ready stays 0.
- rsp_ready asserted outside DONE is ignored.

Test Plan:
- Reset, then LOAD a=0x5A -> rsp_valid 1 cycle after accept, rsp_data=0x5A, rsp_err=0, acc=0x5A, sel stays 0.
- AND a=0xF0 b=0x3C with a datapath model, LOGIC_LAT=1 -> sel=000001 for exactly 1 cycle, rsp_data=0x30 at accept+2.
- SUM a=0xFF b=0x02, wb=1, SUM_LAT=3 -> sel=010000 for 3 cycles, rsp_data=0x01 (wrap), acc=0x01 at accept+4.
- Op 7 -> rsp_err=1, rsp_data=0, acc unchanged, sel never nonzero. Then REG -> rsp_data equals the prior acc, sel=100000.
- Hold rsp_ready=0 for 10 cycles after an XOR -> rsp_data stable, req_ready=0, a second req_valid is ignored. Release -> IDLE, the next request is accepted.
- Assert rst mid-EXEC of a SUM with wb=1 -> next cycle IDLE, sel=0, acc=0, no rsp_valid. Assert for all tests: sel is zero or one-hot every cycle.
